// File: rtl/nsa_pkg.sv
// ============================================================================
// Module   : nsa_pkg
// Purpose  : Shared FSM state encoding and nibble width for nibble_serial_adder.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package nsa_pkg;

    localparam int NIBBLE_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } nsa_state_t;

endpackage : nsa_pkg

`default_nettype wire

// File: rtl/cla_4b_ci.sv
// ============================================================================
// Module   : cla_4b_ci
// Purpose  : Combinational 4-bit carry-lookahead adder slice with carry-in.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cla_4b_ci
    import nsa_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout
);

    logic [NIBBLE_W-1:0] w_p;
    logic [NIBBLE_W-1:0] w_g;
    logic [NIBBLE_W:0]   w_c;

    assign w_p = x ^ y;
    assign w_g = x & y;

    // Every carry is a flat sum of products so cin reaches each stage in one level.
    assign w_c[0] = cin;
    assign w_c[1] = w_g[0] | (w_p[0] & cin);
    assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
    assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                  | (w_p[2] & w_p[1] & w_p[0] & cin);
    assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                  | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                  | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & cin);

    assign s    = w_p ^ w_c[NIBBLE_W-1:0];
    assign cout = w_c[NIBBLE_W];

endmodule : cla_4b_ci

`default_nettype wire

// File: rtl/nibble_serial_adder.sv
// ============================================================================
// Module   : nibble_serial_adder
// Purpose  : WIDTH-bit adder processed one nibble per clock through a 4-bit CLA.
//            Define SUBTRACT_EN to add the sub port (a - b via a + ~b + 1).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_serial_adder
    import nsa_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SUBTRACT_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   sum
);

    localparam int NIB  = WIDTH / NIBBLE_W;
    localparam int IDXW = (NIB > 1) ? $clog2(NIB) : 1;

    nsa_state_t          r_state;
    nsa_state_t          w_state_next;
    logic [WIDTH-1:0]    r_a;
    logic [WIDTH-1:0]    r_b;
    logic                r_carry;
    logic [IDXW-1:0]     r_idx;
    logic [WIDTH:0]      r_sum;
    logic                w_init_carry;
    logic [NIBBLE_W-1:0] w_a_nib;
    logic [NIBBLE_W-1:0] w_b_nib;
    logic [NIBBLE_W-1:0] w_b_eff;
    logic [NIBBLE_W-1:0] w_s;
    logic                w_cout;
    logic                w_last;
    logic [WIDTH:0]      w_sum_next;

`ifdef SUBTRACT_EN
    logic                r_sub;
    assign w_init_carry = sub;
    assign w_b_eff      = r_sub ? ~w_b_nib : w_b_nib;
`else
    assign w_init_carry = 1'b0;
    assign w_b_eff      = w_b_nib;
`endif

    assign w_last = (r_idx == IDXW'(NIB - 1));

    always_comb begin
        w_a_nib = '0;
        w_b_nib = '0;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_a_nib = r_a[NIBBLE_W*n +: NIBBLE_W];
                w_b_nib = r_b[NIBBLE_W*n +: NIBBLE_W];
            end
        end
    end

    cla_4b_ci u_cla (
        .x    (w_a_nib),
        .y    (w_b_eff),
        .cin  (r_carry),
        .s    (w_s),
        .cout (w_cout)
    );

    // The final carry-out lands in the top bit on the last nibble.
    always_comb begin
        w_sum_next = r_sum;
        for (int n = 0; n < NIB; n++) begin
            if (r_idx == IDXW'(n)) begin
                w_sum_next[NIBBLE_W*n +: NIBBLE_W] = w_s;
            end
        end
        if (w_last) begin
            w_sum_next[WIDTH] = w_cout;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                if (w_last) begin
                    w_state_next = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= '0;
            r_b     <= '0;
            r_carry <= 1'b0;
            r_idx   <= '0;
            r_sum   <= '0;
`ifdef SUBTRACT_EN
            r_sub   <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_b     <= b;
                        r_carry <= w_init_carry;
                        r_idx   <= '0;
                        r_sum   <= '0;
`ifdef SUBTRACT_EN
                        r_sub   <= sub;
`endif
                    end
                end
                RUN: begin
                    r_sum   <= w_sum_next;
                    r_carry <= w_cout;
                    if (!w_last) begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign sum = r_sum;

endmodule : nibble_serial_adder

`default_nettype wire

// File: tb/tb_nibble_serial_adder.sv
// ============================================================================
// Module   : tb_nibble_serial_adder
// Purpose  : Scoreboard bench for nibble_serial_adder (SUBTRACT_EN optional).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_serial_adder;

    localparam int WIDTH = 16;
    localparam int NIB   = WIDTH / 4;

    logic             clk;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             sub;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH:0]   sum;

    int checks   = 0;
    int failures = 0;

    logic [WIDTH:0] sb[$];

    nibble_serial_adder #(.WIDTH(WIDTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
`ifdef SUBTRACT_EN
        .sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [WIDTH:0] model(input logic [WIDTH-1:0] ma,
                                             input logic [WIDTH-1:0] mb,
                                             input logic ms);
        logic [WIDTH:0] r;
        if (ms) r = {1'b0, ma} + {1'b0, ~mb} + (WIDTH+1)'(1);
        else    r = {1'b0, ma} + {1'b0, mb};
        return r;
    endfunction

    task automatic run_op(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tb_,
                          input logic ts, input int hold, input bit keep_valid,
                          input string name);
        int cyc;
        logic [WIDTH:0] exp;
        logic [WIDTH:0] held;
        cyc = 0;
        while (in_ready !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s_in_ready_timeout actual=%b required=1", name, in_ready);
            return;
        end
        a = ta; b = tb_; sub = ts; in_valid = 1'b1;
        @(posedge clk); #1;
        sb.push_back(model(ta, tb_, ts));
        if (keep_valid) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom);
        end else begin
            in_valid = 1'b0;
        end
        cyc = 0;
        while (out_valid !== 1'b1 && cyc < 30) begin
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL %s_busy_in_ready actual=%b required=0", name, in_ready);
            end
            @(posedge clk); #1; cyc++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s_out_valid_timeout actual=%b required=1", name, out_valid);
            void'(sb.pop_front());
            return;
        end
        checks++;
        if (cyc != NIB) begin
            failures++;
            $display("FAIL %s_latency actual=%0d required=%0d", name, cyc, NIB);
        end
        exp = sb.pop_front();
        checks++;
        if (sum !== exp) begin
            failures++;
            $display("FAIL %s_sum actual=0x%0h required=0x%0h", name, sum, exp);
        end
        held = sum;
        repeat (hold) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || sum !== held) begin
                failures++;
                $display("FAIL %s_hold actual=v%b r%b 0x%0h required=v1 r0 0x%0h",
                         name, out_valid, in_ready, sum, held);
            end
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_release actual=r%b v%b required=r1 v0", name, in_ready, out_valid);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sub = 1'b0; a = '0; b = '0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0) begin
            failures++;
            $display("FAIL reset_state actual=r%b v%b 0x%0h required=r1 v0 0x0",
                     in_ready, out_valid, sum);
        end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_add();
        run_op(WIDTH'(32'h1234), WIDTH'(32'h4321), 1'b0, 0, 1'b0, "add_basic");
        run_op(WIDTH'(32'hFFFF), WIDTH'(32'h0001), 1'b0, 0, 1'b0, "add_carry_chain");
        run_op(WIDTH'(32'hFFFF), WIDTH'(32'hFFFF), 1'b0, 1, 1'b0, "add_max");
        run_op(WIDTH'(32'h0000), WIDTH'(32'h0000), 1'b0, 0, 1'b0, "add_zero");
    endtask

    task automatic test_back_to_back();
        run_op(WIDTH'(32'hA5A5), WIDTH'(32'h5A5B), 1'b0, 3, 1'b1, "b2b_first");
        run_op(WIDTH'(32'h0F0F), WIDTH'(32'h00F1), 1'b0, 0, 1'b0, "b2b_second");
    endtask

    task automatic test_reset_mid_run();
        a = WIDTH'(32'h1111); b = WIDTH'(32'h2222); sub = 1'b0; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || sum !== '0) begin
            failures++;
            $display("FAIL reset_mid_run actual=r%b v%b 0x%0h required=r1 v0 0x0",
                     in_ready, out_valid, sum);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        run_op(WIDTH'(32'h0001), WIDTH'(32'h0001), 1'b0, 0, 1'b0, "after_reset");
    endtask

`ifdef SUBTRACT_EN
    task automatic test_subtract();
        run_op(WIDTH'(32'h0005), WIDTH'(32'h0007), 1'b1, 0, 1'b0, "sub_borrow");
        run_op(WIDTH'(32'h0007), WIDTH'(32'h0005), 1'b1, 2, 1'b0, "sub_no_borrow");
        run_op(WIDTH'(32'h1234), WIDTH'(32'h1234), 1'b1, 0, 1'b0, "sub_equal");
    endtask
`endif

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            logic rs;
`ifdef SUBTRACT_EN
            rs = 1'($urandom_range(0, 1));
`else
            rs = 1'b0;
`endif
            run_op(WIDTH'($urandom), WIDTH'($urandom), rs,
                   int'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SUBTRACT_EN
        test_subtract();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_nibble_serial_adder

`default_nettype wire
